// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW-hazard stall, taken-branch flush, memory-wait freeze with timeout.
// Optional macro PIPE_STATS_EN adds the stall_cycles statistics counter port.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned BR_FLUSH_LEN = 1,
   parameter int unsigned STALL_CNT_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hazard,
   input  logic       branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       freeze_if,
   output logic       flush_if,
   output logic       flush_id,
   output logic       mem_stall,
   output logic       mem_timeout,
   output logic [1:0] state
`ifdef PIPE_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      FLUSH    = 2'b01,
      MEM_WAIT = 2'b10,
      ERROR    = 2'b11
   } state_e;

   localparam logic [7:0] WAIT_LAST  = 8'(MEM_WAIT_MAX - 1);
   localparam logic [3:0] FLUSH_INIT = 4'(BR_FLUSH_LEN - 1);

   if (MEM_WAIT_MAX < 2 || MEM_WAIT_MAX > 255 || BR_FLUSH_LEN < 1 ||
       BR_FLUSH_LEN > 15 || STALL_CNT_W < 1) begin : g_bad_param
      $error("pipe_hazard_ctrl: parameter out of legal range");
   end

   state_e     state_q, state_d, ret_state_q, ret_state_d;
   logic [3:0] flush_cnt_q, flush_cnt_d, ret_cnt_q, ret_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_q, timeout_d;
   logic       freeze_raw, flush_if_raw, flush_id_raw, stall_raw;
   logic       mem_block;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         ret_state_q <= RUN;
         flush_cnt_q <= '0;
         ret_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         flush_cnt_q <= flush_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ret_state_d  = ret_state_q;
      flush_cnt_d  = flush_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;
      freeze_raw   = 1'b0;
      flush_if_raw = 1'b0;
      flush_id_raw = 1'b0;
      stall_raw    = 1'b0;
      mem_block    = mem_req & ~mem_ready;

      case (state_q)
         RUN, FLUSH: begin
            if (mem_block) begin
               // The stalled cycle itself is the first counted wait cycle.
               stall_raw   = 1'b1;
               freeze_raw  = 1'b1;
               ret_state_d = state_q;
               ret_cnt_d   = flush_cnt_q;
               wait_cnt_d  = 8'd1;
               state_d     = MEM_WAIT;
            end else if (state_q == FLUSH) begin
               flush_if_raw = 1'b1;
               flush_id_raw = 1'b1;
               if (flush_cnt_q <= 4'd1) begin
                  flush_cnt_d = '0;
                  state_d     = RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q - 4'd1;
               end
            end else if (branch_taken) begin
               flush_if_raw = 1'b1;
               flush_id_raw = 1'b1;
               if (BR_FLUSH_LEN > 1) begin
                  flush_cnt_d = FLUSH_INIT;
                  state_d     = FLUSH;
               end
            end else if (hazard) begin
               freeze_raw   = 1'b1;
               flush_id_raw = 1'b1;
            end
         end
         MEM_WAIT: begin
            stall_raw  = ~mem_ready;
            freeze_raw = ~mem_ready;
            if (mem_ready) begin
               wait_cnt_d  = '0;
               state_d     = ret_state_q;
               flush_cnt_d = ret_cnt_q;
            end else if (wait_cnt_q >= WAIT_LAST) begin
               state_d   = ERROR;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            stall_raw  = 1'b1;
            freeze_raw = 1'b1;
         end
      endcase
   end

   // Mealy outputs are forced low for the whole time reset is held.
   assign freeze_if   = rst & freeze_raw;
   assign flush_if    = rst & flush_if_raw;
   assign flush_id    = rst & flush_id_raw;
   assign mem_stall   = rst & stall_raw;
   assign mem_timeout = timeout_q;
   assign state       = state_q;

`ifdef PIPE_STATS_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if ((freeze_if | mem_stall) && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_WAIT_MAX=4, BR_FLUSH_LEN=2).
module tb_pipe_hazard_ctrl;

   localparam int W = 7;   // {state[1:0], freeze_if, flush_if, flush_id, mem_stall, mem_timeout}

   logic clk = 1'b0;
   logic rst, hazard, branch_taken, mem_req, mem_ready;
   logic freeze_if, flush_if, flush_id, mem_stall, mem_timeout;
   logic [1:0] state;
`ifdef PIPE_STATS_EN
   logic [2:0] stall_cycles;
`endif

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks   = 0;
   int           failures = 0;

   pipe_hazard_ctrl #(
      .MEM_WAIT_MAX(4),
      .BR_FLUSH_LEN(2),
      .STALL_CNT_W (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hazard      (hazard),
      .branch_taken(branch_taken),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .freeze_if   (freeze_if),
      .flush_if    (flush_if),
      .flush_id    (flush_id),
      .mem_stall   (mem_stall),
      .mem_timeout (mem_timeout),
      .state       (state)
`ifdef PIPE_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs shortly after the edge and queue that cycle's expected outputs.
   task automatic drive(input logic r, input logic h, input logic b, input logic mr,
                        input logic rd, input logic [1:0] st, input logic fz,
                        input logic fi, input logic fd, input logic ms, input logic mt,
                        input string nm);
      @(posedge clk);
      #2;
      rst          = r;
      hazard       = h;
      branch_taken = b;
      mem_req      = mr;
      mem_ready    = rd;
      exp_q.push_back({st, fz, fi, fd, ms, mt});
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
   always @(negedge clk) begin : monitor
      logic [W-1:0] e;
      string        n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, {state, freeze_if, flush_if, flush_id, mem_stall, mem_timeout}, e);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      #1 rst = 1'b0;

      //     r  h  b  mr rd  st    fz fi fd ms mt
      drive(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, "reset_force_zero");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "after_release_idle");

`ifdef PIPE_STATS_EN
      drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "stats_hz1");
      drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "stats_hz2");
      drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "stats_hz3");
      drive(1, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0, "stats_st1");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "stats_st2");
      drive(1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, "stats_ready");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "stats_idle");
      @(negedge clk); #1;
      check("stall_cycles_5", {4'b0, stall_cycles}, 7'd5);
`endif

      // Single hazard cycle: freeze + bubble, no state change.
      drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "hazard_freeze");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "hazard_after");

      // Branch beats hazard; second flush cycle ignores hazard.
      drive(1, 1, 1, 0, 0, 2'b00, 0, 1, 1, 0, 0, "branch_flush1");
      drive(1, 1, 0, 0, 0, 2'b01, 0, 1, 1, 0, 0, "branch_flush2");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "branch_done");

      // Two stall cycles then ready.
      drive(1, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0, "mem_stall1");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "mem_stall2");
      drive(1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, "mem_ready");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "mem_back_run");

      // Branch, then a stall lands in FLUSH; remaining flush issued after ready.
      drive(1, 0, 1, 0, 0, 2'b00, 0, 1, 1, 0, 0, "bm_branch");
      drive(1, 0, 0, 1, 0, 2'b01, 1, 0, 0, 1, 0, "bm_stall_in_flush");
      drive(1, 1, 1, 1, 0, 2'b10, 1, 0, 0, 1, 0, "bm_wait_ignores_br");
      drive(1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, "bm_ready");
      drive(1, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0, 0, "bm_resumed_flush");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "bm_run");

      // Memory stall outranks a simultaneous branch.
      drive(1, 0, 1, 1, 0, 2'b00, 1, 0, 0, 1, 0, "prio_stall_over_br");
      drive(1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, "prio_ready");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "prio_run");

      // Ready on the 4th stall cycle avoids ERROR.
      drive(1, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0, "edge_w1");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "edge_w2");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "edge_w3");
      drive(1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, "edge_w4_ready");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "edge_run");

      // Four stall cycles without ready -> ERROR, sticky, inputs ignored.
      drive(1, 0, 0, 1, 0, 2'b00, 1, 0, 0, 1, 0, "to_w1");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "to_w2");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "to_w3");
      drive(1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1, 0, "to_w4");
      drive(1, 1, 1, 0, 1, 2'b11, 1, 0, 0, 1, 1, "error_entered");
      drive(1, 1, 1, 1, 1, 2'b11, 1, 0, 0, 1, 1, "error_sticky");

      // Asynchronous reset mid-ERROR: outputs drop immediately.
      @(negedge clk); #1;
      rst = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check("rst_async_outputs", {state, freeze_if, flush_if, flush_id, mem_stall, mem_timeout}, 7'b0);
      drive(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, "rst_held");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "rst_release_run");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "rst_no_resume");

`ifdef PIPE_STATS_EN
      drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "sat_hz1");
      repeat (8) drive(1, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, "sat_hz");
      drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "sat_idle");
      @(negedge clk); #1;
      check("stall_cycles_sat", {4'b0, stall_cycles}, 7'd7);
`endif

      @(negedge clk); #1;
      check("scoreboard_drained", 7'(exp_q.size()), 7'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
